miter_seq_checker: RTL and testbench

MITER_SEQ_CHECKER -- requirements
Module: miter_seq_checker

---
 rtl/miter_seq_checker.sv | 212 +++++++++++++++++++++
 tb/tb_miter_seq_checker.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miter_seq_checker.sv
// rtl/miter_seq_checker.sv - sequential miter comparing a gold vector stream against a latency-shifted gate stream
//
// Ports:
//   i_clk            sole clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_start          open a session (clears counters, flags and alignment pipeline); wins over i_stop
//   i_stop           close the current session (ignored in IDLE/DONE)
//   i_in_valid       gold/care sample valid
//   i_gold           reference-netlist vector
//   i_gate           implementation-netlist vector, GATE_LAT cycles behind i_gold
//   i_care           per-bit compare enable (0 = don't care)
//   o_state          IDLE=0, RUN=1, FAIL=2, DONE=3
//   o_busy           high in RUN or FAIL
//   o_pass           verdict of the last closed session
//   o_fail           sticky mismatch flag for the session
//   o_sample_cnt     compared samples (saturating)
//   o_mismatch_cnt   mismatching samples (saturating)
//   o_first_idx      index of the first mismatching sample
//   o_first_diff     (gold^gate)&care of the first mismatching sample
//
// Build option: MITER_FIRST_FAIL_EN enables the first-mismatch capture registers;
// without it o_first_idx and o_first_diff are tied to 0.

module miter_seq_checker #(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 16,
    parameter int GATE_LAT    = 0,
    parameter int MIN_SAMPLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_gold,
    input  logic [WIDTH-1:0] i_gate,
    input  logic [WIDTH-1:0] i_care,
    output logic [1:0]       o_state,
    output logic             o_busy,
    output logic             o_pass,
    output logic             o_fail,
    output logic [CNT_W-1:0] o_sample_cnt,
    output logic [CNT_W-1:0] o_mismatch_cnt,
    output logic [CNT_W-1:0] o_first_idx,
    output logic [WIDTH-1:0] o_first_diff
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FAIL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             r_pass;
    logic             r_fail;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_mismatch_cnt;

    logic             w_active;
    logic             w_stop_take;
    logic             w_pipe_clr;
    logic             w_vld_d;
    logic [WIDTH-1:0] w_gold_d;
    logic [WIDTH-1:0] w_care_d;
    logic [WIDTH-1:0] w_diff;
    logic             w_cmp;
    logic             w_mis;
    logic [CNT_W-1:0] w_scnt_nxt;
    logic [CNT_W-1:0] w_mcnt_inc;
    logic             w_fail_nxt;
    logic             w_pass_verdict;

    assign w_active    = (r_state == S_RUN) || (r_state == S_FAIL);
    assign w_stop_take = i_stop && !i_start && w_active;
    // Samples still in flight belong to the session being opened or closed; drop them.
    assign w_pipe_clr  = i_start || w_stop_take;

    // Alignment pipeline: delays gold/care/valid so they meet the late gate vector.
    generate
        if (GATE_LAT == 0) begin : g_no_pipe
            assign w_vld_d  = i_in_valid;
            assign w_gold_d = i_gold;
            assign w_care_d = i_care;
        end else begin : g_pipe
            logic [GATE_LAT-1:0] r_vld_pipe;
            logic [WIDTH-1:0]    r_gold_pipe [GATE_LAT];
            logic [WIDTH-1:0]    r_care_pipe [GATE_LAT];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_vld_pipe <= '0;
                    for (int k = 0; k < GATE_LAT; k++) begin
                        r_gold_pipe[k] <= '0;
                        r_care_pipe[k] <= '0;
                    end
                end else begin
                    r_vld_pipe[0]  <= w_pipe_clr ? 1'b0 : i_in_valid;
                    r_gold_pipe[0] <= i_gold;
                    r_care_pipe[0] <= i_care;
                    for (int k = 1; k < GATE_LAT; k++) begin
                        r_vld_pipe[k]  <= w_pipe_clr ? 1'b0 : r_vld_pipe[k-1];
                        r_gold_pipe[k] <= r_gold_pipe[k-1];
                        r_care_pipe[k] <= r_care_pipe[k-1];
                    end
                end
            end

            assign w_vld_d  = r_vld_pipe[GATE_LAT-1];
            assign w_gold_d = r_gold_pipe[GATE_LAT-1];
            assign w_care_d = r_care_pipe[GATE_LAT-1];
        end
    endgenerate

    assign w_diff     = (w_gold_d ^ i_gate) & w_care_d;
    assign w_cmp      = w_vld_d && w_active;
    assign w_mis      = w_cmp && (|w_diff);
    assign w_scnt_nxt = !w_cmp ? r_sample_cnt :
                        (&r_sample_cnt) ? r_sample_cnt : r_sample_cnt + CNT_W'(1);
    assign w_mcnt_inc = (&r_mismatch_cnt) ? r_mismatch_cnt : r_mismatch_cnt + CNT_W'(1);
    assign w_fail_nxt = r_fail || w_mis;
    // Verdict includes the sample compared in the stop cycle itself.
    assign w_pass_verdict = (r_state == S_RUN) && !w_fail_nxt &&
                            (w_scnt_nxt >= CNT_W'(MIN_SAMPLES));

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (i_start) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN:   w_state_nxt = i_stop ? S_DONE : (w_mis ? S_FAIL : S_RUN);
                S_FAIL:  w_state_nxt = i_stop ? S_DONE : S_FAIL;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        o_state = r_state;
        o_busy  = w_active;
    end

    // Session counters and flags; frozen outside RUN/FAIL.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pass         <= 1'b0;
            r_fail         <= 1'b0;
            r_sample_cnt   <= '0;
            r_mismatch_cnt <= '0;
        end else if (i_start) begin
            r_pass         <= 1'b0;
            r_fail         <= 1'b0;
            r_sample_cnt   <= '0;
            r_mismatch_cnt <= '0;
        end else if (w_active) begin
            r_sample_cnt <= w_scnt_nxt;
            r_fail       <= w_fail_nxt;
            if (w_mis) begin
                r_mismatch_cnt <= w_mcnt_inc;
            end
            if (w_stop_take) begin
                r_pass <= w_pass_verdict;
            end
        end
    end

    assign o_pass         = r_pass;
    assign o_fail         = r_fail;
    assign o_sample_cnt   = r_sample_cnt;
    assign o_mismatch_cnt = r_mismatch_cnt;

`ifdef MITER_FIRST_FAIL_EN
    logic [CNT_W-1:0] r_first_idx;
    logic [WIDTH-1:0] r_first_diff;

    // Loads only while the sticky flag is still clear, i.e. on the session's first mismatch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_first_idx  <= '0;
            r_first_diff <= '0;
        end else if (i_start) begin
            r_first_idx  <= '0;
            r_first_diff <= '0;
        end else if (w_mis && !r_fail) begin
            r_first_idx  <= r_sample_cnt;
            r_first_diff <= w_diff;
        end
    end

    assign o_first_idx  = r_first_idx;
    assign o_first_diff = r_first_diff;
`else
    assign o_first_idx  = '0;
    assign o_first_diff = '0;
`endif

endmodule

// File: tb/tb_miter_seq_checker.sv
// tb/tb_miter_seq_checker.sv - self-checking bench for miter_seq_checker (GATE_LAT 0 and 2 instances)

module tb_miter_seq_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, stop, vld;
    logic [7:0] gold, care, gate0, gate2;

    logic [1:0]  st0, st2;
    logic        busy0, busy2, pass0, pass2, fail0, fail2;
    logic [15:0] scnt0, mcnt0, fidx0;
    logic [3:0]  scnt2, mcnt2, fidx2;
    logic [7:0]  fdiff0, fdiff2;

    miter_seq_checker #(.WIDTH(8), .CNT_W(16), .GATE_LAT(0), .MIN_SAMPLES(4)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_in_valid(vld),
        .i_gold(gold), .i_gate(gate0), .i_care(care),
        .o_state(st0), .o_busy(busy0), .o_pass(pass0), .o_fail(fail0),
        .o_sample_cnt(scnt0), .o_mismatch_cnt(mcnt0), .o_first_idx(fidx0), .o_first_diff(fdiff0));

    miter_seq_checker #(.WIDTH(8), .CNT_W(4), .GATE_LAT(2), .MIN_SAMPLES(4)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_in_valid(vld),
        .i_gold(gold), .i_gate(gate2), .i_care(care),
        .o_state(st2), .o_busy(busy2), .o_pass(pass2), .o_fail(fail2),
        .o_sample_cnt(scnt2), .o_mismatch_cnt(mcnt2), .o_first_idx(fidx2), .o_first_diff(fdiff2));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-instance session view plus a short input history.
    int         m_st   [2];
    bit         m_pass [2];
    bit         m_fail [2];
    int         m_scnt [2];
    int         m_mcnt [2];
    int         m_fidx [2];
    logic [7:0] m_fdiff[2];
    bit         hv [2][3];
    logic [7:0] hg [2][3];
    logic [7:0] hc [2][3];
    logic [7:0] g_prev [2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_st[d] = 0; m_pass[d] = 0; m_fail[d] = 0;
            m_scnt[d] = 0; m_mcnt[d] = 0; m_fidx[d] = 0; m_fdiff[d] = 8'h00;
            for (int k = 0; k < 3; k++) begin
                hv[d][k] = 0; hg[d][k] = 8'h00; hc[d][k] = 8'h00;
            end
        end
    endfunction

    function automatic void model_cycle(input int d, input logic [7:0] gt);
        int         lat, mx;
        bit         run, cmp, mis, clr;
        logic [7:0] diff;
        lat = (d == 0) ? 0 : 2;
        mx  = (d == 0) ? 65535 : 15;
        for (int k = 2; k > 0; k--) begin
            hv[d][k] = hv[d][k-1]; hg[d][k] = hg[d][k-1]; hc[d][k] = hc[d][k-1];
        end
        hv[d][0] = vld; hg[d][0] = gold; hc[d][0] = care;
        run  = (m_st[d] == 1) || (m_st[d] == 2);
        cmp  = hv[d][lat] && run;
        diff = (hg[d][lat] ^ gt) & hc[d][lat];
        mis  = cmp && (diff != 8'h00);
        clr  = 0;
        if (start) begin
            m_st[d] = 1; m_pass[d] = 0; m_fail[d] = 0;
            m_scnt[d] = 0; m_mcnt[d] = 0; m_fidx[d] = 0; m_fdiff[d] = 8'h00;
            clr = 1;
        end else if (run) begin
            int st_old;
            st_old = m_st[d];
            if (cmp) begin
                if (mis && !m_fail[d]) begin
                    m_fidx[d] = m_scnt[d]; m_fdiff[d] = diff;
                end
                if (m_scnt[d] < mx) m_scnt[d]++;
                if (mis && m_mcnt[d] < mx) m_mcnt[d]++;
                if (mis) m_fail[d] = 1;
            end
            if (mis) m_st[d] = 2;
            if (stop) begin
                m_pass[d] = (st_old == 1) && !m_fail[d] && (m_scnt[d] >= 4);
                m_st[d] = 3;
                clr = 1;
            end
        end
        if (clr) for (int k = 0; k < 3; k++) hv[d][k] = 0;
    endfunction

    task automatic check_model(input int d);
        logic [31:0] a_st, a_busy, a_pass, a_fail, a_scnt, a_mcnt, a_fidx, a_fdiff;
        int e_fidx, e_fdiff;
        if (d == 0) begin
            a_st = 32'(st0); a_busy = 32'(busy0); a_pass = 32'(pass0); a_fail = 32'(fail0);
            a_scnt = 32'(scnt0); a_mcnt = 32'(mcnt0); a_fidx = 32'(fidx0); a_fdiff = 32'(fdiff0);
        end else begin
            a_st = 32'(st2); a_busy = 32'(busy2); a_pass = 32'(pass2); a_fail = 32'(fail2);
            a_scnt = 32'(scnt2); a_mcnt = 32'(mcnt2); a_fidx = 32'(fidx2); a_fdiff = 32'(fdiff2);
        end
`ifdef MITER_FIRST_FAIL_EN
        e_fidx = m_fidx[d]; e_fdiff = int'(m_fdiff[d]);
`else
        e_fidx = 0; e_fdiff = 0;
`endif
        chk($sformatf("model_state[%0d]", d), a_st, 32'(m_st[d]));
        chk($sformatf("model_busy[%0d]", d), a_busy, 32'((m_st[d] == 1) || (m_st[d] == 2)));
        chk($sformatf("model_pass[%0d]", d), a_pass, 32'(m_pass[d]));
        chk($sformatf("model_fail[%0d]", d), a_fail, 32'(m_fail[d]));
        chk($sformatf("model_sample_cnt[%0d]", d), a_scnt, 32'(m_scnt[d]));
        chk($sformatf("model_mismatch_cnt[%0d]", d), a_mcnt, 32'(m_mcnt[d]));
        chk($sformatf("model_first_idx[%0d]", d), a_fidx, 32'(e_fidx));
        chk($sformatf("model_first_diff[%0d]", d), a_fdiff, 32'(e_fdiff));
    endtask

    // Apply the currently driven inputs for one clock and check both instances.
    task automatic step();
        model_cycle(0, gate0);
        model_cycle(1, gate2);
        @(posedge clk);
        #1;
        g_prev[1] = g_prev[0];
        g_prev[0] = gold;
        check_model(0);
        check_model(1);
    endtask

    task automatic drive(input bit s, input bit p, input bit v, input logic [7:0] g,
                         input logic [7:0] gt0, input logic [7:0] c, input logic [7:0] flip2);
        start = s; stop = p; vld = v; gold = g; gate0 = gt0; care = c;
        gate2 = g_prev[1] ^ flip2;
    endtask

    typedef struct {
        bit          s, p, v;
        logic [7:0]  g, gt, c;
        logic [1:0]  e_st;
        bit          e_pass, e_fail;
        logic [15:0] e_scnt, e_mcnt;
    } vec_t;

    function automatic vec_t mk(input bit s, input bit p, input bit v, input logic [7:0] g,
                                input logic [7:0] gt, input logic [7:0] c, input logic [1:0] e_st,
                                input bit e_pass, input bit e_fail, input int e_scnt, input int e_mcnt);
        vec_t r;
        r.s = s; r.p = p; r.v = v; r.g = g; r.gt = gt; r.c = c;
        r.e_st = e_st; r.e_pass = e_pass; r.e_fail = e_fail;
        r.e_scnt = 16'(e_scnt); r.e_mcnt = 16'(e_mcnt);
        return r;
    endfunction

    vec_t vt[$];

    initial begin
        rst_n = 1'b0;
        g_prev[0] = 8'h00; g_prev[1] = 8'h00;
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(st0), 32'd0);
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_sample_cnt", 32'(scnt0), 32'd0);
        check_model(0);
        check_model(1);
        rst_n = 1'b1;

        // Six clean samples then stop: pass.
        vt.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 6; i++) vt.push_back(mk(0, 0, 1, 8'hA5, 8'hA5, 8'hFF, 1, 0, 0, i, 0));
        vt.push_back(mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 3, 1, 0, 6, 0));
        // Differences only in don't-care bits.
        vt.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++) vt.push_back(mk(0, 0, 1, 8'hF0, 8'h00, 8'h0F, 1, 0, 0, i, 0));
        vt.push_back(mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 3, 1, 0, 4, 0));
        // Below MIN_SAMPLES, then start+stop together, stop with no samples, stop in DONE.
        vt.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 3; i++) vt.push_back(mk(0, 0, 1, 8'h3C, 8'h3C, 8'hFF, 1, 0, 0, i, 0));
        vt.push_back(mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 3, 0, 0, 3, 0));
        vt.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 3, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 8'h11, 8'h22, 8'hFF, 3, 0, 0, 0, 0));
        // Mismatch in the stop cycle.
        vt.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++) vt.push_back(mk(0, 0, 1, 8'h5A, 8'h5A, 8'hFF, 1, 0, 0, i, 0));
        vt.push_back(mk(0, 1, 1, 8'hA5, 8'h5A, 8'hFF, 3, 0, 1, 5, 1));
        // Fourth sample arrives in the stop cycle and counts toward the verdict.
        vt.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 3; i++) vt.push_back(mk(0, 0, 1, 8'h77, 8'h77, 8'hFF, 1, 0, 0, i, 0));
        vt.push_back(mk(0, 1, 1, 8'h77, 8'h77, 8'hFF, 3, 1, 0, 4, 0));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].s, vt[i].p, vt[i].v, vt[i].g, vt[i].gt, vt[i].c, 8'h00);
            step();
            chk($sformatf("vec%0d_state", i), 32'(st0), 32'(vt[i].e_st));
            chk($sformatf("vec%0d_pass", i), 32'(pass0), 32'(vt[i].e_pass));
            chk($sformatf("vec%0d_fail", i), 32'(fail0), 32'(vt[i].e_fail));
            chk($sformatf("vec%0d_sample_cnt", i), 32'(scnt0), 32'(vt[i].e_scnt));
            chk($sformatf("vec%0d_mismatch_cnt", i), 32'(mcnt0), 32'(vt[i].e_mcnt));
        end

        // Two-cycle gate lag: sample 5 has gate bit 3 flipped.
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, (i < 6), (i < 6) ? 8'(8'h30 + i) : 8'h00, (i < 6) ? 8'(8'h30 + i) : 8'h00,
                  8'hFF, (i == 7) ? 8'h08 : 8'h00);
            step();
        end
        chk("lat2_state", 32'(st2), 32'd2);
        chk("lat2_fail", 32'(fail2), 32'd1);
        chk("lat2_sample_cnt", 32'(scnt2), 32'd6);
        chk("lat2_mismatch_cnt", 32'(mcnt2), 32'd1);
`ifdef MITER_FIRST_FAIL_EN
        chk("lat2_first_idx", 32'(fidx2), 32'd5);
        chk("lat2_first_diff", 32'(fdiff2), 32'h08);
`else
        chk("lat2_first_idx", 32'(fidx2), 32'd0);
        chk("lat2_first_diff", 32'(fdiff2), 32'h00);
`endif

        // Saturation on the 4-bit instance: 20 mismatching samples.
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        for (int i = 0; i < 22; i++) begin
            logic [7:0] g;
            g = 8'($urandom);
            drive(0, 0, (i < 20), g, g, 8'hFF, 8'hFF);
            step();
        end
        chk("sat_mismatch_cnt", 32'(mcnt2), 32'hF);
        chk("sat_sample_cnt", 32'(scnt2), 32'hF);
        chk("sat_mismatch_cnt_lat0", 32'(mcnt0), 32'd0);
        chk("sat_sample_cnt_lat0", 32'(scnt0), 32'd20);

        // Asynchronous reset mid-session, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state0", 32'(st0), 32'd0);
        chk("arst_sample_cnt0", 32'(scnt0), 32'd0);
        chk("arst_state2", 32'(st2), 32'd0);
        chk("arst_mismatch_cnt2", 32'(mcnt2), 32'd0);
        chk("arst_fail2", 32'(fail2), 32'd0);
        chk("arst_first_diff2", 32'(fdiff2), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized sessions against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] g, c, f0, f2;
            g  = 8'($urandom);
            c  = ($urandom_range(0, 7) == 0) ? 8'h00 :
                 ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            f0 = ($urandom_range(0, 11) == 0) ? 8'($urandom) : 8'h00;
            f2 = ($urandom_range(0, 11) == 0) ? 8'($urandom) : 8'h00;
            drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 7), g, g ^ f0, c, f2);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
